// File: rtl/aes_pkg.sv
// aes_pkg: AES-128 constants (S-box, Rcon) and GF(2^8)/byte-index helpers.
package aes_pkg;
  localparam int NR = 10;
  localparam logic [79:0] RCON = 80'h01020408102040801b36;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  // Round numbers outside 1..NR map to zero so idle cycles never index out of range.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    int i;
    i = (r >= 4'd1 && r <= 4'd10) ? 10 - int'(r) : 0;
    return (r >= 4'd1 && r <= 4'd10) ? RCON[8*i +: 8] : 8'h00;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] get_byte(input logic [127:0] s, input int n);
    return s[127-8*n -: 8];
  endfunction

  function automatic int idx(input int r, input int c);
    return 4*c + r;
  endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_a,
  output logic [7:0] o_y
);
  assign o_y = SBOX[8*(255-int'(i_a)) +: 8];
endmodule

// File: rtl/aes128_encrypt.sv
// aes128_encrypt: iterative AES-128 encryptor, one round per clock, on-the-fly key expansion.
// Defining AES_DEBUG_EN adds round/state outputs and per-round SubBytes/ShiftRows/MixColumns taps.
module aes128_encrypt
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] data_in,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic [127:0] data_out
`ifdef AES_DEBUG_EN
  ,
  output logic [3:0]   dbg_round,
  output logic [127:0] dbg_state,
  output logic [127:0] dbg_sbytes,
  output logic [127:0] dbg_shiftrows,
  output logic [127:0] dbg_mixcol
`endif
);
  logic [127:0] r_state, r_rk, r_data_out;
  logic [3:0]   r_round;
  logic         r_busy, r_done;
  logic [127:0] w_sb, w_sr, w_mc, w_nk, w_next;
  logic [31:0]  w_rot, w_sw, w_w0, w_w1, w_w2, w_w3;
  logic         w_last;

  for (genvar i = 0; i < 16; i++) begin : g_sb
    aes_sbox u_sb (.i_a(get_byte(r_state, i)), .o_y(w_sb[127-8*i -: 8]));
    assign w_sr[127-8*i -: 8] = get_byte(w_sb, idx(i % 4, (i / 4 + i % 4) % 4));
  end

  for (genvar c = 0; c < 4; c++) begin : g_mc
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign {w_a0, w_a1, w_a2, w_a3} = w_sr[127-32*c -: 32];
    assign w_mc[127-32*c -: 32] = {gmul2(w_a0) ^ gmul3(w_a1) ^ w_a2 ^ w_a3,
                                   w_a0 ^ gmul2(w_a1) ^ gmul3(w_a2) ^ w_a3,
                                   w_a0 ^ w_a1 ^ gmul2(w_a2) ^ gmul3(w_a3),
                                   gmul3(w_a0) ^ w_a1 ^ w_a2 ^ gmul2(w_a3)};
  end

  // Key schedule: RotWord then SubWord on the last word of the current round key.
  assign w_rot = {r_rk[23:0], r_rk[31:24]};
  for (genvar k = 0; k < 4; k++) begin : g_sw
    aes_sbox u_sw (.i_a(w_rot[31-8*k -: 8]), .o_y(w_sw[31-8*k -: 8]));
  end
  assign w_w0 = r_rk[127:96] ^ w_sw ^ {rcon(r_round), 24'h0};
  assign w_w1 = r_rk[95:64] ^ w_w0;
  assign w_w2 = r_rk[63:32] ^ w_w1;
  assign w_w3 = r_rk[31:0] ^ w_w2;
  assign w_nk = {w_w0, w_w1, w_w2, w_w3};

  assign w_last = r_round == 4'(NR);
  assign w_next = (w_last ? w_sr : w_mc) ^ w_nk;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= '0;
      r_rk       <= '0;
      r_round    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        if (start) begin
          r_state <= data_in ^ key;
          r_rk    <= key;
          r_round <= 4'd1;
          r_busy  <= 1'b1;
        end
      end else begin
        r_state <= w_next;
        r_rk    <= w_nk;
        r_round <= w_last ? 4'd0 : r_round + 4'd1;
        r_busy  <= !w_last;
        if (w_last) begin
          r_data_out <= w_next;
          r_done     <= 1'b1;
        end
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign data_out = r_data_out;

`ifdef AES_DEBUG_EN
  assign dbg_round     = r_round;
  assign dbg_state     = r_state;
  assign dbg_sbytes    = w_sb;
  assign dbg_shiftrows = w_sr;
  assign dbg_mixcol    = w_mc;
`endif
endmodule

// File: tb/tb_aes128_encrypt.sv
// tb_aes128_encrypt: scoreboard bench for aes128_encrypt against a byte-array AES reference model.
module tb_aes128_encrypt;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CZ = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [127:0] data_in = '0, key = '0;
  logic busy, done;
  logic [127:0] data_out;
`ifdef AES_DEBUG_EN
  logic [3:0] dbg_round;
  logic [127:0] dbg_state, dbg_sbytes, dbg_shiftrows, dbg_mixcol;
`endif

  aes128_encrypt dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .key(key),
    .busy(busy), .done(done), .data_out(data_out)
`ifdef AES_DEBUG_EN
    , .dbg_round(dbg_round), .dbg_state(dbg_state), .dbg_sbytes(dbg_sbytes),
    .dbg_shiftrows(dbg_shiftrows), .dbg_mixcol(dbg_mixcol)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // Reference model: generic GF multiply, S-box derived from inverse + affine map.
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] b);
    logic [7:0] inv = 0, y;
    for (int x = 1; x < 256; x++) if (gmul(b, 8'(x)) == 8'h01) inv = 8'(x);
    y = 8'h63 ^ inv;
    for (int k = 1; k < 5; k++) y ^= (inv << k) | (inv >> (8 - k));
    return y;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0] s [16], t [16], rc = 8'h01;
    logic [31:0] w [44], tmp;
    logic [127:0] out;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
        tmp[31:24] ^= rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[4*c+r] = (rnd < 10) ? gmul(t[4*c+r], 8'h02) ^ gmul(t[4*c+(r+1)%4], 8'h03)
                                  ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4] : t[4*c+r];
      for (int i = 0; i < 16; i++) s[i] ^= w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
    return out;
  endfunction

  typedef struct packed {logic [127:0] d; logic [31:0] c;} exp_t;
  exp_t sb [$];
  exp_t mon_e;
  logic rst_q;
  bit armed = 0;
  logic [127:0] hold = '0;

  always @(posedge clk) rst_q <= rst;

  // Monitor: reset state, ciphertext+latency on done, otherwise data_out must hold.
  always @(negedge clk) begin
    if (rst_q === 1'b1) begin
      armed = 1;
      chk("rst_data_out", data_out, '0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_done", 128'(done), 128'd0);
      hold = '0;
    end else if (armed) begin
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: data_out=%h with no pending block", data_out);
        end else begin
          mon_e = sb.pop_front();
          chk("data_out", data_out, mon_e.d);
          chk("done_cycle", 128'(cyc), 128'(mon_e.c));
          chk("busy_at_done", 128'(busy), 128'd0);
          hold = mon_e.d;
        end
      end else chk("data_out_hold", data_out, hold);
    end
  end

  task automatic wait_idle();
    @(negedge clk);
    for (int i = 0; i < 40 && busy !== 1'b0; i++) @(negedge clk);
    if (busy !== 1'b0) chk("idle_timeout", 128'(busy), 128'd0);
  endtask

  task automatic issue(input logic [127:0] p, input logic [127:0] k, input logic [127:0] e);
    wait_idle();
    data_in = p;
    key = k;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    sb.push_back('{e, 32'(cyc + 10)});
    chk("busy_after_start", 128'(busy), 128'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("drain_timeout", 128'(sb.size()), 128'd0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  int t0;
  logic [127:0] rp, rk;

  initial begin
    for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    issue(P1, K1, C1);
`ifdef AES_DEBUG_EN
    chk("dbg_round", 128'(dbg_round), 128'd1);
    chk("dbg_state", dbg_state, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    chk("dbg_sbytes", dbg_sbytes, 128'hd42711aee0bf98f1b8b45de51e415230);
    chk("dbg_shiftrows", dbg_shiftrows, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
    chk("dbg_mixcol", dbg_mixcol, 128'h046681e5e0cb199a48f8d37a2806264c);
`endif
    drain();
    issue(P2, K2, C2);
    drain();
    // Back-to-back with start held: second block is sampled 11 edges after the first.
    wait_idle();
    data_in = P1;
    key = K1;
    start = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    sb.push_back('{C1, 32'(t0 + 10)});
    data_in = P2;
    key = K2;
    repeat (11) @(posedge clk);
    #1 start = 1'b0;
    sb.push_back('{C2, 32'(t0 + 21)});
    chk("b2b_busy", 128'(busy), 128'd1);
    drain();
    // Start pulse with new operands while busy must be ignored.
    issue(P1, K1, C1);
    repeat (5) @(negedge clk);
    data_in = {$urandom, $urandom, $urandom, $urandom};
    key = {$urandom, $urandom, $urandom, $urandom};
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    drain();
    repeat (4) @(negedge clk);
    // Reset mid-operation aborts without a done pulse.
    issue(P1, K1, C1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    start = 1'b0;
    sb.delete();
    repeat (12) @(negedge clk);
    chk("post_rst_busy", 128'(busy), 128'd0);
    issue(P2, K2, C2);
    drain();
    issue('0, '0, CZ);
    drain();
    repeat (8) begin
      rp = {$urandom, $urandom, $urandom, $urandom};
      rk = {$urandom, $urandom, $urandom, $urandom};
      issue(rp, rk, aes_ref(rp, rk));
      repeat ($urandom_range(0, 14)) @(negedge clk);
    end
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
